// File: rtl/clkgate_en_ctrl.sv
// ============================================================================
// clkgate_en_ctrl
// ----------------------------------------------------------------------------
// Activity-driven enable generator for a clock-gated domain. The registered
// clk_en output feeds the domain's clock header. The enable stays high while
// any source is busy. It drops after HYST consecutive idle cycles and comes
// back one cycle after new activity appears. A WAKE_CYC-cycle wake window
// keeps requesters stalled until the gated domain is clocking again. A
// saturating counter records how many cycles the domain spent gated, for
// power profiling.
//
// Parameters:
//   NUM_SRC  - number of activity sources (>= 1)
//   HYST     - consecutive idle cycles before gating (>= 1)
//   WAKE_CYC - cycles spent in WAKE, with clk_en high, before release (>= 1)
//   PERF_W   - width of the gated-cycle counter
//
// Ports:
//   clk          in   free-running (ungated) clock
//   rst          in   asynchronous, active-high reset
//   activity     in   per-source busy level, held until serviced
//   force_on     in   override that counts as activity (never gate)
//   perf_clr     in   synchronous clear of gated_cycles
//   clk_en       out  registered enable to the clock header (1 = clocked)
//   gated        out  1 while the domain is gated
//   stall        out  1 while not ACTIVE; requesters must hold off
//   gated_cycles out  saturating count of cycles spent gated
// ============================================================================
module clkgate_en_ctrl #(
    parameter int NUM_SRC  = 4,
    parameter int HYST     = 8,
    parameter int WAKE_CYC = 2,
    parameter int PERF_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_SRC-1:0]  activity,
    input  logic                force_on,
    input  logic                perf_clr,
    output logic                clk_en,
    output logic                gated,
    output logic                stall,
    output logic [PERF_W-1:0]   gated_cycles
);

    localparam int IDLE_W = $clog2(HYST + 1);
    localparam int WAKE_W = $clog2(WAKE_CYC + 1);

    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(HYST - 1);
    localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYC - 1);

    // Two-bit encoding. The unused code 2'b11 is handled explicitly and
    // steers back to ACTIVE, so the state can never stick in an undefined
    // code.
    typedef enum logic [1:0] {
        ST_ACTIVE = 2'b00,
        ST_GATED  = 2'b01,
        ST_WAKE   = 2'b10
    } state_e;

    state_e              state_q,   state_d;
    logic                clkEn_q,   clkEn_d;
    logic [IDLE_W-1:0]   idleCnt_q, idleCnt_d;
    logic [WAKE_W-1:0]   wakeCnt_q, wakeCnt_d;
    logic [PERF_W-1:0]   gatedCnt_q, gatedCnt_d;

    logic idle;

    // The domain is idle only when every source is quiet and no override
    // is active. All sources are OR-reduced, so several busy sources look
    // the same as one.
    always_comb begin
        idle = ~(|activity) & ~force_on;
    end

    // State register. Reset sets clk_en to 1 so that asserting reset while
    // the domain is gated starts its clock again at once, without waiting
    // for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_ACTIVE;
            clkEn_q   <= 1'b1;
            idleCnt_q <= '0;
            wakeCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clkEn_q   <= clkEn_d;
            idleCnt_q <= idleCnt_d;
            wakeCnt_q <= wakeCnt_d;
        end
    end

    // Next-state logic. clk_en is computed here together with the state,
    // so the enable register changes on the same edge as the state
    // register. The clock header therefore sees a clean flop output.
    always_comb begin
        state_d   = state_q;
        clkEn_d   = clkEn_q;
        idleCnt_d = idleCnt_q;
        wakeCnt_d = wakeCnt_q;

        case (state_q)
            ST_ACTIVE: begin
                clkEn_d   = 1'b1;
                wakeCnt_d = '0;
                if (!idle) begin
                    // Any activity, even on the cycle the idle run would
                    // complete, restarts the hysteresis window.
                    idleCnt_d = '0;
                end else if (idleCnt_q == IDLE_LAST) begin
                    state_d   = ST_GATED;
                    clkEn_d   = 1'b0;
                    idleCnt_d = '0;
                end else begin
                    idleCnt_d = idleCnt_q + IDLE_W'(1);
                end
            end

            ST_GATED: begin
                clkEn_d   = 1'b0;
                idleCnt_d = '0;
                wakeCnt_d = '0;
                if (!idle) begin
                    state_d = ST_WAKE;
                    clkEn_d = 1'b1;
                end
            end

            ST_WAKE: begin
                // Idle is ignored while waking. The domain always runs
                // through the full wake window before it can gate again.
                clkEn_d   = 1'b1;
                idleCnt_d = '0;
                if (wakeCnt_q == WAKE_LAST) begin
                    state_d   = ST_ACTIVE;
                    wakeCnt_d = '0;
                end else begin
                    wakeCnt_d = wakeCnt_q + WAKE_W'(1);
                end
            end

            default: begin
                state_d   = ST_ACTIVE;
                clkEn_d   = 1'b1;
                idleCnt_d = '0;
                wakeCnt_d = '0;
            end
        endcase
    end

    // Output decode. gated and stall depend only on the state register,
    // never on the inputs, so they are stable for the whole cycle.
    always_comb begin
        gated = (state_q == ST_GATED);
        stall = (state_q != ST_ACTIVE);
    end

    // Gated-cycle counter next value. A clear takes priority over counting.
    // The counter stops at all-ones so that long gated stretches never wrap
    // back to a small number.
    always_comb begin
        gatedCnt_d = gatedCnt_q;
        if (perf_clr) begin
            gatedCnt_d = '0;
        end else if ((state_q == ST_GATED) && (gatedCnt_q != '1)) begin
            gatedCnt_d = gatedCnt_q + PERF_W'(1);
        end
    end

    // Gated-cycle counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gatedCnt_q <= '0;
        end else begin
            gatedCnt_q <= gatedCnt_d;
        end
    end

    assign clk_en       = clkEn_q;
    assign gated_cycles = gatedCnt_q;

    // Invariants of the encoding: the enable is low exactly when the domain
    // is gated, and both counters stay inside their windows.
    a_en_matches_state: assert property (
        @(posedge clk) disable iff (rst)
        ((state_q == ST_GATED) == !clkEn_q)
    );

    a_idle_in_range: assert property (
        @(posedge clk) disable iff (rst)
        (idleCnt_q <= IDLE_LAST)
    );

    a_wake_in_range: assert property (
        @(posedge clk) disable iff (rst)
        ((state_q != ST_WAKE) || (wakeCnt_q <= WAKE_LAST))
    );

endmodule
